// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/issue control FSM driving pc_unit over a req/ack instruction bus
module pc_sequencer #(
   parameter logic [15:0] IRQ_VECTOR   = 16'h0004,
   parameter logic [15:0] FAULT_VECTOR = 16'h0008,
   parameter int          MEM_TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] pc,
   output logic        pc_en,
   output logic [1:0]  pc_op,
   output logic [15:0] pc_target,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   input  logic        long_insn,
   output logic [15:0] instr,
   output logic [15:0] imm,
   output logic        instr_valid,
   input  logic        exec_done,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   input  logic        irq,
   input  logic        irq_en,
   output logic        irq_ack,
   output logic [15:0] epc,
   output logic        fetch_fault
);
   localparam logic [1:0] PC_NOP = 2'd0, PC_INC = 2'd1, PC_SET = 2'd2, PC_RESET = 2'd3;
   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   typedef enum logic [2:0] {RST, FETCH, FETCH_IMM, ISSUE, TRAP} state_t;
   state_t state, state_nx;
   logic [CW-1:0] wcnt;
   logic fetching, timeout, ack;
   assign fetching = (state == FETCH) || (state == FETCH_IMM);
   assign timeout  = fetching && (wcnt == CW'(MEM_TIMEOUT));
   assign ack      = fetching && !timeout && mem_ack;
   // next state and pc_unit/bus controls, decoded from state plus same-cycle handshakes
   always_comb begin
      state_nx    = state;
      pc_en       = 1'b0;
      pc_op       = PC_NOP;
      pc_target   = '0;
      mem_req     = 1'b0;
      mem_addr    = '0;
      instr_valid = 1'b0;
      irq_ack     = 1'b0;
      fetch_fault = 1'b0;
      case (state)
         RST: begin
            pc_en    = 1'b1;
            pc_op    = PC_RESET;
            state_nx = FETCH;
         end
         FETCH, FETCH_IMM: begin
            if (timeout) begin
               fetch_fault = 1'b1;
               pc_en       = 1'b1;
               pc_op       = PC_SET;
               pc_target   = FAULT_VECTOR;
               state_nx    = FETCH;
            end else begin
               mem_req  = 1'b1;
               mem_addr = pc;
               if (mem_ack) begin
                  pc_en    = 1'b1;
                  pc_op    = PC_INC;
                  state_nx = (state == FETCH && long_insn) ? FETCH_IMM : ISSUE;
               end
            end
         end
         ISSUE: begin
            instr_valid = 1'b1;
            if (exec_done) begin
               pc_en     = branch_taken;
               pc_op     = branch_taken ? PC_SET : PC_NOP;
               pc_target = branch_taken ? {branch_target[15:1], 1'b0} : '0;
               state_nx  = (irq && irq_en) ? TRAP : FETCH;
            end
         end
         TRAP: begin
            irq_ack   = 1'b1;
            pc_en     = 1'b1;
            pc_op     = PC_SET;
            pc_target = IRQ_VECTOR;
            state_nx  = FETCH;
         end
         default: state_nx = RST;
      endcase
   end
   // state register
   always_ff @(posedge clk)
      state <= rst ? RST : state_nx;
   // instruction latches, return address and fetch wait counter
   always_ff @(posedge clk) begin
      if (rst) begin
         instr <= '0;
         imm   <= '0;
         epc   <= '0;
         wcnt  <= '0;
      end else begin
         wcnt <= (fetching && !timeout && !mem_ack) ? wcnt + 1'b1 : '0;
         if (ack && state == FETCH) begin
            instr <= mem_rdata;
            if (!long_insn) imm <= '0;
         end
         if (ack && state == FETCH_IMM) imm <= mem_rdata;
         if (timeout || state == TRAP) epc <= pc;
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized fetch/execute traffic checked against an instruction-level pc model
module tb_pc_sequencer;
   localparam logic [15:0] IRQ_V = 16'h0004, FAULT_V = 16'h0008;
   localparam int TMO = 16;
   localparam logic [1:0] PC_INC = 2'd1, PC_SET = 2'd2, PC_RESET = 2'd3;
   logic clk = 1'b0, rst = 1'b1;
   logic [15:0] pc, pc_target, mem_addr, mem_rdata = '0, instr, imm, branch_target = '0, epc;
   logic [1:0] pc_op;
   logic pc_en, mem_req, mem_ack = 1'b0, long_insn = 1'b0, instr_valid, exec_done = 1'b0;
   logic branch_taken = 1'b0, irq = 1'b0, irq_en = 1'b0, irq_ack, fetch_fault;
   int checks = 0, errors = 0;
   logic [15:0] exp_pc;
   pc_sequencer #(.IRQ_VECTOR(IRQ_V), .FAULT_VECTOR(FAULT_V), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en), .pc_op(pc_op), .pc_target(pc_target),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .long_insn(long_insn), .instr(instr), .imm(imm), .instr_valid(instr_valid),
      .exec_done(exec_done), .branch_taken(branch_taken), .branch_target(branch_target),
      .irq(irq), .irq_en(irq_en), .irq_ack(irq_ack), .epc(epc), .fetch_fault(fetch_fault)
   );
   always #5 clk = ~clk;
   // pc_unit stand-in: reset to 0, +2 with wrap, or load
   always @(posedge clk)
      if (pc_en === 1'b1)
         pc <= (pc_op == PC_RESET) ? 16'h0000 : (pc_op == PC_INC) ? pc + 16'd2 : (pc_op == PC_SET) ? pc_target : pc;
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic expect_fetch(input string tag, input logic [15:0] addr);
      #1;
      chk({tag, "_req"}, mem_req, 1'b1);
      chk(tag, mem_addr, addr);
   endtask
   task automatic fetch_word(input logic [15:0] addr, input logic [15:0] data, input logic lng,
                             input int dly, output logic faulted);
      faulted = 1'b0;
      for (int i = 0; i < dly && i < TMO; i++) begin
         mem_ack = 1'b0; mem_rdata = 16'($urandom); long_insn = 1'($urandom);
         exec_done = 1'($urandom); branch_taken = 1'($urandom);
         #1;
         chk("wait_req", mem_req, 1'b1);
         chk("wait_addr", mem_addr, addr);
         chk("wait_pc_en", pc_en, 1'b0);
         chk("wait_valid", instr_valid, 1'b0);
         step();
      end
      if (dly >= TMO) begin
         mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
         #1;
         chk("tmo_req", mem_req, 1'b0);
         chk("tmo_fault", fetch_fault, 1'b1);
         chk("tmo_op", pc_op, PC_SET);
         chk("tmo_target", pc_target, FAULT_V);
         step();
         mem_ack = 1'b0;
         #1;
         chk("tmo_pulse", fetch_fault, 1'b0);
         chk("tmo_epc", epc, addr);
         faulted = 1'b1;
      end else begin
         mem_ack = 1'b1; mem_rdata = data; long_insn = lng; exec_done = 1'($urandom);
         #1;
         chk("ack_req", mem_req, 1'b1);
         chk("ack_addr", mem_addr, addr);
         chk("ack_pc_en", pc_en, 1'b1);
         chk("ack_op", pc_op, PC_INC);
         step();
         mem_ack = 1'b0;
      end
   endtask
   task automatic run_insn(input logic lng, input logic [15:0] op, input logic [15:0] im, input int d0,
                           input int d1, input int ed, input logic br, input logic [15:0] tgt,
                           input logic ir, input logic ire);
      logic f;
      logic [15:0] a, nxt;
      a = exp_pc;
      fetch_word(a, op, lng, d0, f);
      if (f) begin exp_pc = FAULT_V; return; end
      if (lng) begin
         fetch_word(a + 16'd2, im, 1'b0, d1, f);
         if (f) begin exp_pc = FAULT_V; return; end
      end
      nxt = br ? {tgt[15:1], 1'b0} : a + (lng ? 16'd4 : 16'd2);
      for (int i = 0; i <= ed; i++) begin
         exec_done = (i == ed); branch_taken = (i == ed) ? br : 1'($urandom);
         branch_target = (i == ed) ? tgt : 16'($urandom);
         irq = (i == ed) ? ir : 1'($urandom); irq_en = (i == ed) ? ire : 1'($urandom);
         #1;
         chk("iss_valid", instr_valid, 1'b1);
         chk("iss_instr", instr, op);
         chk("iss_imm", imm, lng ? im : 16'h0000);
         chk("iss_req", mem_req, 1'b0);
         if (i < ed) begin
            chk("iss_hold_en", pc_en, 1'b0);
            step();
         end
      end
      chk("exec_pc_en", pc_en, br);
      if (br) begin
         chk("br_op", pc_op, PC_SET);
         chk("br_target", pc_target, nxt);
      end
      step();
      exec_done = 1'b0; branch_taken = 1'b0; irq = 1'b0;
      #1;
      chk("irq_ack", irq_ack, ir & ire);
      if (ir && ire) begin
         chk("trap_op", pc_op, PC_SET);
         chk("trap_target", pc_target, IRQ_V);
         chk("trap_valid", instr_valid, 1'b0);
         step();
         #1;
         chk("trap_pulse", irq_ack, 1'b0);
         chk("trap_epc", epc, nxt);
         exp_pc = IRQ_V;
      end else
         exp_pc = nxt;
   endtask
   task automatic mid_reset();
      rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'($urandom); long_insn = 1'($urandom);
      step();
      mem_ack = 1'b0;
      #1;
      chk("mrst_op", pc_op, PC_RESET);
      chk("mrst_req", mem_req, 1'b0);
      chk("mrst_valid", instr_valid, 1'b0);
      chk("mrst_instr", instr, 16'h0000);
      chk("mrst_epc", epc, 16'h0000);
      rst = 1'b0;
      step();
      exp_pc = 16'h0000;
   endtask
   function automatic int pick_delay();
      int r;
      r = $urandom_range(0, 19);
      return (r == 0) ? TMO : (r == 1) ? TMO - 1 : $urandom_range(0, 3);
   endfunction
   initial begin
      step();
      step();
      chk("rst_op", pc_op, PC_RESET);
      chk("rst_en", pc_en, 1'b1);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_epc", epc, 16'h0000);
      rst = 1'b0;
      #1;
      chk("rel_op", pc_op, PC_RESET);
      step();
      chk("rel_op_once", pc_op, 2'd0);
      exp_pc = 16'h0000;
      expect_fetch("first_fetch", 16'h0000);
      run_insn(1'b0, 16'h1234, 16'h0000, 0, 0, 1, 1'b0, 16'h0000, 1'b0, 1'b0);
      expect_fetch("short_next", 16'h0002);
      run_insn(1'b0, 16'h2222, 16'h0000, 0, 0, 0, 1'b1, 16'h0010, 1'b0, 1'b0);
      run_insn(1'b1, 16'h8001, 16'hBEEF, 3, 3, 0, 1'b0, 16'h0000, 1'b0, 1'b0);
      expect_fetch("long_next", 16'h0014);
      run_insn(1'b0, 16'h3333, 16'h0000, 0, 0, 0, 1'b1, 16'h0101, 1'b0, 1'b0);
      expect_fetch("br_fetch", 16'h0100);
      run_insn(1'b0, 16'h4444, 16'h0000, 0, 0, 2, 1'b1, 16'h0200, 1'b1, 1'b1);
      chk("irq_epc", epc, 16'h0200);
      expect_fetch("irq_fetch", IRQ_V);
      run_insn(1'b0, 16'h5555, 16'h0000, 1, 0, 0, 1'b1, 16'h0040, 1'b0, 1'b0);
      run_insn(1'b0, 16'h6666, 16'h0000, TMO, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0);
      chk("fault_epc", epc, 16'h0040);
      expect_fetch("fault_fetch", FAULT_V);
      run_insn(1'b0, 16'h7777, 16'h0000, TMO - 1, 0, 0, 1'b0, 16'h0000, 1'b1, 1'b0);
      expect_fetch("no_fault_next", 16'h000A);
      run_insn(1'b0, 16'h9999, 16'h0000, 0, 0, 0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_insn(1'b0, 16'hAAAA, 16'h0000, 0, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0);
      expect_fetch("wrap_fetch", 16'h0000);
      mid_reset();
      for (int n = 0; n < 300; n++)
         run_insn(1'($urandom), 16'($urandom), 16'($urandom), pick_delay(), pick_delay(),
                  $urandom_range(0, 3), 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      mid_reset();
      run_insn(1'b1, 16'hC0DE, 16'hF00D, 0, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0);
      expect_fetch("post_rst_next", 16'h0004);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
